// File: rtl/div_seq.sv
// div_seq -- sequential signed divider for the multicycle CPU datapath.
//
// Restoring shift-subtract on operand magnitudes, one quotient bit per clock,
// followed by a single sign-correction cycle. Quotient truncates toward zero
// and the remainder takes the sign of the dividend (MIPS DIV semantics).
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   reset     asynchronous, active-low; clears all state immediately
//   start     request, sampled only in IDLE
//   a_in      dividend (signed), captured on the start edge
//   b_in      divisor (signed), captured on the start edge
//   hi        remainder of the last completed division (Hi register path)
//   lo        quotient of the last completed division (Lo register path)
//   busy      high from the start edge until the done edge
//   done      one-cycle pulse when a result or div_zero is valid
//   div_zero  one-cycle pulse coincident with done when the divisor was 0
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; hi/lo hold the last result
// CALC  | one restoring shift-subtract iteration per cycle (WIDTH total)
// FIX   | sign-correct quotient/remainder and write hi/lo
// DONE  | done (and div_zero if flagged) asserted for one cycle

module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic [WIDTH-1:0] rem_next;
    logic             rem_ge;
    logic             last_iter;
    logic             b_is_zero;
    logic             launch;

    // The shifted remainder can reach 2*|b|-1, so it needs WIDTH+1 bits.
    // The borrow out of the trial subtraction doubles as the compare:
    // a non-negative difference is always below 2^WIDTH, a negative one
    // always wraps to at least 2^WIDTH.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, b_mag};
        rem_ge    = ~rem_sub[WIDTH];
        rem_next  = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        last_iter = (cnt == CW'(WIDTH - 1));
        b_is_zero = (b_in == '0);
        launch    = (state == IDLE) && start;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = b_is_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe, with no input-to-output path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy     <= (state_next != IDLE);
            done     <= (state_next == DONE);
            div_zero <= launch && b_is_zero;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            quo    <= '0;
            rem    <= '0;
            b_mag  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_a <= a_in[WIDTH-1];
                        sign_b <= b_in[WIDTH-1];
                        // Magnitude of the most negative value wraps to
                        // itself, which is the correct unsigned magnitude.
                        quo    <= a_in[WIDTH-1] ? -a_in : a_in;
                        b_mag  <= b_in[WIDTH-1] ? -b_in : b_in;
                        rem    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= {quo[WIDTH-2:0], rem_ge};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    lo <= (sign_a ^ sign_b) ? -quo : quo;
                    hi <= sign_a ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq -- self-checking bench for div_seq.
// Expected results are pushed to a scoreboard queue when a division is
// launched and popped when the divider reports done.

module tb_div_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;
    logic          div_zero;

    div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    // 64-bit arithmetic cannot overflow on -2^31 / -1; truncating to 32 bits
    // then gives the wrapped quotient.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] plo, input logic [31:0] phi);
        exp_t   e;
        longint sa, sd, q, r;
        if (b == 32'd0) begin
            e.lo = plo; e.hi = phi; e.dz = 1'b1; e.lat = 0;
        end else begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
            q  = sa / sd;
            r  = sa % sd;
            e.lo = q[31:0]; e.hi = r[31:0]; e.dz = 1'b0; e.lat = W + 1;
        end
        return e;
    endfunction

    // Drives start for one edge (E0) and records the expected result.
    // Returns 1 ns after E0.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        e = model(a, b, last_lo, last_hi);
        sbq.push_back(e);
        last_lo = e.lo;
        last_hi = e.hi;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting edges since E0 (pre = edges already
    // elapsed), then checks latency, busy, results and the pulse widths.
    task automatic run_div(input string name, input int pre);
        exp_t e;
        int   k;
        logic busy_ok;
        k = pre;
        busy_ok = 1'b1;
        while (done !== 1'b1 && k < W + 8) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        e = sbq.pop_front();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s done_timeout: done=%b after %0d edges, required 1", name, done, k);
        end
        n_cmp++;
        if (k !== e.lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, k, e.lat);
        end
        n_cmp++;
        if (busy_ok !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_during_op: busy dropped (busy=%b at done), required 1 throughout", name, busy);
        end
        n_cmp++;
        if (lo !== e.lo) begin
            n_err++;
            $display("FAIL %s lo: got %h, required %h", name, lo, e.lo);
        end
        n_cmp++;
        if (hi !== e.hi) begin
            n_err++;
            $display("FAIL %s hi: got %h, required %h", name, hi, e.hi);
        end
        n_cmp++;
        if (div_zero !== e.dz) begin
            n_err++;
            $display("FAIL %s div_zero: got %b, required %b", name, div_zero, e.dz);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({done, busy, div_zero} !== 3'b000) begin
            n_err++;
            $display("FAIL %s after_done: done/busy/div_zero=%b%b%b, required 000", name, done, busy, div_zero);
        end
        n_cmp++;
        if (lo !== e.lo || hi !== e.hi) begin
            n_err++;
            $display("FAIL %s hold: lo/hi=%h/%h, required %h/%h", name, lo, hi, e.lo, e.hi);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_cmp++;
        if ({hi, lo} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_hilo: hi=%h lo=%h, required 0", hi, lo);
        end
        n_cmp++;
        if ({busy, done, div_zero} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: busy/done/div_zero=%b%b%b, required 000", busy, done, div_zero);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        launch(32'd100, 32'd7);
        run_div("div_100_7", 0);
    endtask

    task automatic test_signs();
        launch(-32'sd7, 32'd2);
        run_div("div_m7_2", 0);
        launch(32'd7, -32'sd2);
        run_div("div_7_m2", 0);
        launch(-32'sd7, -32'sd2);
        run_div("div_m7_m2", 0);
    endtask

    task automatic test_overflow();
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        run_div("div_min_m1", 0);
        launch(32'h8000_0000, 32'd1);
        run_div("div_min_1", 0);
        launch(32'h7FFF_FFFF, 32'h8000_0000);
        run_div("div_max_min", 0);
    endtask

    task automatic test_div_zero();
        launch(32'd9, 32'd4);
        run_div("preload_9_4", 0);
        launch(32'd5, 32'd0);
        run_div("div_5_0", 0);
    endtask

    task automatic test_ignore_start();
        launch(32'd1000, 32'd10);
        repeat (2) begin
            @(negedge clk);
            a_in  = 32'd5;
            b_in  = 32'd1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        run_div("ignore_start", 2);
    endtask

    task automatic test_abort();
        logic seen_done;
        @(negedge clk);
        a_in  = 32'd100;
        b_in  = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        a_in  = 32'd9;
        b_in  = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_busy: busy=%b, required 1", busy);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({hi, lo} !== 64'd0 || {busy, done, div_zero} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_clear: hi=%h lo=%h busy/done/dz=%b%b%b, required all 0", hi, lo, busy, done, div_zero);
        end
        last_lo = '0;
        last_hi = '0;
        @(negedge clk);
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: activity seen after reset=%b, required 0", seen_done);
        end
        launch(32'd9, 32'd3);
        run_div("after_abort_9_3", 0);
    endtask

    task automatic test_back_to_back();
        launch(32'd123456, -32'sd321);
        run_div("b2b_first", 0);
        launch(-32'sd99, 32'd10);
        run_div("b2b_second", 0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 2))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 100);
                default: b = -$urandom_range(1, 100);
            endcase
            if (b == 32'd0) b = 32'd3;
            if ((i % 4) == 1) a = a >> $urandom_range(0, 31);
            launch(a, b);
            run_div("random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
